// File: rtl/leg_pkg.sv
// Shared definitions for the leg pipeline front end: micro-op store geometry,
// slot field layout, the decoded slot/bundle types and the sequencer states.
package leg_pkg;

    localparam int UOP_BUF_SIZE           = 128;
    localparam int UOP_BUF_WIDTH          = 72;
    localparam int MAX_PREDICT_DEPTH_BITS = 2;
    localparam int ADDR_W                 = $clog2(UOP_BUF_SIZE);

    // Field offsets inside one 36-bit slot: [35:4] instr, [3:2] tag, [1] spec, [0] valid
    localparam int VALID_BIT = 0;
    localparam int SPEC_BIT  = 1;
    localparam int TAG_LSB   = 2;
    localparam int INSTR_LSB = TAG_LSB + MAX_PREDICT_DEPTH_BITS;
    localparam int INSTR_W   = 32;
    localparam int SLOT_W    = INSTR_LSB + INSTR_W;

    // Slot 0 (older) occupies the upper half of the bundle
    localparam int SLOT0_LSB = SLOT_W;
    localparam int SLOT1_LSB = 0;

    typedef struct packed {
        logic [INSTR_W-1:0]                instr;
        logic [MAX_PREDICT_DEPTH_BITS-1:0] tag;
        logic                              spec;
        logic                              valid;
    } uop_slot_t;

    typedef struct packed {
        uop_slot_t s0;
        uop_slot_t s1;
    } uop_bundle_t;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } mcu_state_t;

endpackage

// File: rtl/microcode_slot_decode.sv
// Splits one 36-bit store slot into its fields; an invalid slot is presented
// as all zeros so nothing stale leaks downstream.
module microcode_slot_decode
    import leg_pkg::*;
(
    input  logic [SLOT_W-1:0] i_slot,
    output uop_slot_t         o_slot
);

    // Field extraction with zero-when-invalid masking
    always_comb begin
        o_slot = '0;
        if (i_slot[VALID_BIT]) begin
            o_slot.instr = i_slot[INSTR_LSB +: INSTR_W];
            o_slot.tag   = i_slot[TAG_LSB +: MAX_PREDICT_DEPTH_BITS];
            o_slot.spec  = i_slot[SPEC_BIT];
            o_slot.valid = 1'b1;
        end else begin
            o_slot = '0;
        end
    end

endmodule

// File: rtl/microcode_unit.sv
// Microcode sequencer: walks the external micro-op store one bundle per cycle,
// registers both issue slots, and stops at the first empty bundle or the end
// of the store. Optional issue counter enabled by MICROCODE_PERF_EN.
module microcode_unit
    import leg_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    output logic [ADDR_W-1:0]                 uop_addr,
    input  logic [UOP_BUF_WIDTH-1:0]          uop,
    output logic [31:0]                       slot_instr [0:1],
    output logic [MAX_PREDICT_DEPTH_BITS-1:0] slot_tag   [0:1],
    output logic                              slot_spec  [0:1],
    output logic                              slot_valid [0:1],
    output logic                              halted
`ifdef MICROCODE_PERF_EN
    ,
    output logic [31:0]                       issue_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(UOP_BUF_SIZE - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    mcu_state_t        r_state;
    mcu_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    uop_bundle_t       r_slots;
    uop_bundle_t       w_slots_nxt;
    uop_bundle_t       w_dec;
    logic              r_halted;
    logic              w_halted_nxt;

    microcode_slot_decode u_dec0 (
        .i_slot (uop[SLOT0_LSB +: SLOT_W]),
        .o_slot (w_dec.s0)
    );

    microcode_slot_decode u_dec1 (
        .i_slot (uop[SLOT1_LSB +: SLOT_W]),
        .o_slot (w_dec.s1)
    );

    // Next-state, next-address and next slot contents
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_slots_nxt  = '0;
        w_halted_nxt = r_halted;
        case (r_state)
            ST_FETCH: begin
                if (!w_dec.s0.valid && !w_dec.s1.valid) begin
                    // Empty bundle terminates the program; address holds
                    w_state_nxt  = ST_HALT;
                    w_halted_nxt = 1'b1;
                end else begin
                    w_slots_nxt = w_dec;
                    if (r_addr == LAST_ADDR) begin
                        // Last bundle still issues, but no wrap to 0
                        w_state_nxt  = ST_HALT;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_addr_nxt = r_addr + ADDR_ONE;
                    end
                end
            end
            ST_HALT: begin
                w_slots_nxt  = '0;
                w_halted_nxt = 1'b1;
            end
            default: begin
                // Unreachable encoding: park safely with outputs quiet
                w_state_nxt  = ST_HALT;
                w_halted_nxt = 1'b1;
            end
        endcase
    end

    // Sequencer state, address and registered slot outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_FETCH;
            r_addr   <= '0;
            r_slots  <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_slots  <= w_slots_nxt;
            r_halted <= w_halted_nxt;
        end
    end

`ifdef MICROCODE_PERF_EN
    logic [31:0] r_issue_cnt;
    logic [31:0] w_issue_cnt_nxt;
    logic [31:0] w_inc;

    // Saturating add of the number of slots latched this edge
    always_comb begin
        w_inc = {31'd0, w_slots_nxt.s0.valid} + {31'd0, w_slots_nxt.s1.valid};
        if (r_issue_cnt > (32'hFFFF_FFFF - w_inc)) begin
            w_issue_cnt_nxt = 32'hFFFF_FFFF;
        end else begin
            w_issue_cnt_nxt = r_issue_cnt + w_inc;
        end
    end

    // Issue counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issue_cnt <= 32'd0;
        end else begin
            r_issue_cnt <= w_issue_cnt_nxt;
        end
    end

    assign issue_cnt = r_issue_cnt;
`endif

    assign uop_addr      = r_addr;
    assign halted        = r_halted;
    assign slot_instr[0] = r_slots.s0.instr;
    assign slot_instr[1] = r_slots.s1.instr;
    assign slot_tag[0]   = r_slots.s0.tag;
    assign slot_tag[1]   = r_slots.s1.tag;
    assign slot_spec[0]  = r_slots.s0.spec;
    assign slot_spec[1]  = r_slots.s1.spec;
    assign slot_valid[0] = r_slots.s0.valid;
    assign slot_valid[1] = r_slots.s1.valid;

endmodule

// File: tb/tb_microcode_unit.sv
// Self-checking bench for microcode_unit: a behavioural store/sequencer model
// checked every cycle, plus hand-computed literal checkpoints per scenario.
// Build with +define+MICROCODE_PERF_EN to also check issue_cnt.
module tb_microcode_unit;

    logic        clk;
    logic        reset;
    logic [6:0]  uop_addr;
    logic [71:0] uop;
    logic [31:0] slot_instr [0:1];
    logic [1:0]  slot_tag   [0:1];
    logic        slot_spec  [0:1];
    logic        slot_valid [0:1];
    logic        halted;
`ifdef MICROCODE_PERF_EN
    logic [31:0] issue_cnt;
`endif

    logic [71:0] mem [0:127];

    int checks;
    int failures;

    microcode_unit dut (
        .clk        (clk),
        .reset      (reset),
        .uop_addr   (uop_addr),
        .uop        (uop),
        .slot_instr (slot_instr),
        .slot_tag   (slot_tag),
        .slot_spec  (slot_spec),
        .slot_valid (slot_valid),
        .halted     (halted)
`ifdef MICROCODE_PERF_EN
        ,
        .issue_cnt  (issue_cnt)
`endif
    );

    // The store answers combinationally for whatever address the DUT drives
    assign uop = mem[uop_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_addr;
    bit          m_halted;
    logic [31:0] m_instr [0:1];
    logic [1:0]  m_tag   [0:1];
    logic        m_spec  [0:1];
    logic        m_valid [0:1];
    longint      m_cnt;

    // Model: one bundle consumed per edge until empty bundle or end of store
    always @(posedge clk or negedge reset) begin
        logic [71:0] b;
        logic [35:0] s;
        if (!reset) begin
            m_addr = 0; m_halted = 0; m_cnt = 0;
            for (int k = 0; k < 2; k++) begin
                m_instr[k] = 0; m_tag[k] = 0; m_spec[k] = 0; m_valid[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_instr[k] = 0; m_tag[k] = 0; m_spec[k] = 0; m_valid[k] = 0;
            end
            if (!m_halted) begin
                b = mem[m_addr];
                if (b[36] == 1'b0 && b[0] == 1'b0) begin
                    m_halted = 1;
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        s = (k == 0) ? b[71:36] : b[35:0];
                        if (s[0]) begin
                            m_instr[k] = s[35:4]; m_tag[k] = s[3:2];
                            m_spec[k] = s[1]; m_valid[k] = 1'b1;
                            m_cnt = m_cnt + 1;
                        end
                    end
                    if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
                    if (m_addr == 127) m_halted = 1;
                    else m_addr = m_addr + 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of DUT against model, away from the active edge
    always @(negedge clk) begin
        check("addr", 64'(uop_addr), 64'(m_addr));
        check("halted", 64'(halted), 64'(m_halted));
        for (int k = 0; k < 2; k++) begin
            check("instr", 64'(slot_instr[k]), 64'(m_instr[k]));
            check("tag", 64'(slot_tag[k]), 64'(m_tag[k]));
            check("spec", 64'(slot_spec[k]), 64'(m_spec[k]));
            check("valid", 64'(slot_valid[k]), 64'(m_valid[k]));
        end
`ifdef MICROCODE_PERF_EN
        check("issue_cnt", 64'(issue_cnt), 64'(m_cnt));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 72'd0;
    endtask

    task automatic load_s1();
        logic [35:0] s;
        clear_mem();
        s = {32'h01205021, 2'd2, 1'b1, 1'b1};
        for (int i = 0; i < 20; i++) mem[i] = {s, s};
    endtask

    // Assert reset away from the clock edge, let the caller load the store,
    // then release on a falling edge
    task automatic hold_reset();
        #2 reset = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        clear_mem();
        #12;
        check("rst_addr", 64'(uop_addr), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_valid0", 64'(slot_valid[0]), 64'd0);

        // Scenario 1: 20 identical bundles then an empty one
        load_s1();
        release_reset();
        step(5);
        check("s1_addr5", 64'(uop_addr), 64'd5);
        check("s1_instr0", 64'(slot_instr[0]), 64'h01205021);
        check("s1_instr1", 64'(slot_instr[1]), 64'h01205021);
        check("s1_tag0", 64'(slot_tag[0]), 64'd2);
        check("s1_spec1", 64'(slot_spec[1]), 64'd1);
        step(15);
        check("s1_addr20", 64'(uop_addr), 64'd20);
        check("s1_live20", 64'(slot_valid[1]), 64'd1);
        check("s1_nohalt20", 64'(halted), 64'd0);
        step(2);
        check("s1_halted", 64'(halted), 64'd1);
        check("s1_addr_hold", 64'(uop_addr), 64'd20);
        check("s1_cleared", 64'(slot_valid[0]), 64'd0);
`ifdef MICROCODE_PERF_EN
        check("s1_cnt", 64'(issue_cnt), 64'd40);
`endif

        // Scenario 2: reset mid-run at address 7
        hold_reset();
        release_reset();
        step(7);
        check("s2_addr7", 64'(uop_addr), 64'd7);
        #2 reset = 1'b0;
        #1;
        check("s2_rst_addr", 64'(uop_addr), 64'd0);
        check("s2_rst_valid", 64'(slot_valid[0]), 64'd0);
        check("s2_rst_instr", 64'(slot_instr[0]), 64'd0);
        release_reset();
        step(3);
        check("s2_restart", 64'(uop_addr), 64'd3);

        // Scenario 3: half-valid bundle, then a tag-3 bundle, then empty
        hold_reset();
        clear_mem();
        mem[0] = {32'h25270004, 2'd0, 1'b0, 1'b1, 32'h25270005, 2'd1, 1'b1, 1'b0};
        mem[1] = {32'hDEADBEEF, 2'd3, 1'b0, 1'b1, 32'hCAFEF00D, 2'd3, 1'b1, 1'b1};
        release_reset();
        step(1);
        check("s3_valid0", 64'(slot_valid[0]), 64'd1);
        check("s3_valid1", 64'(slot_valid[1]), 64'd0);
        check("s3_instr0", 64'(slot_instr[0]), 64'h25270004);
        check("s3_instr1", 64'(slot_instr[1]), 64'd0);
        check("s3_tag1", 64'(slot_tag[1]), 64'd0);
        check("s3_spec1", 64'(slot_spec[1]), 64'd0);
`ifdef MICROCODE_PERF_EN
        check("s3_cnt", 64'(issue_cnt), 64'd1);
`endif
        step(1);
        check("s3_addr2", 64'(uop_addr), 64'd2);
        check("s3_tag3", 64'(slot_tag[0]), 64'd3);
        check("s3_instr1b", 64'(slot_instr[1]), 64'hCAFEF00D);
        step(1);
        check("s3_halted", 64'(halted), 64'd1);

        // Scenario 4: full store, must stop at 127 without wrapping
        hold_reset();
        for (int i = 0; i < 128; i++) begin
            mem[i] = {32'(i * 3 + 1), 2'(i), 1'(i >> 2), 1'b1,
                      ~32'(i), 2'(3 - (i % 4)), 1'(i & 1), 1'b1};
        end
        release_reset();
        step(127);
        check("s4_addr127", 64'(uop_addr), 64'd127);
        check("s4_nohalt", 64'(halted), 64'd0);
        step(1);
        check("s4_halted", 64'(halted), 64'd1);
        check("s4_addr_end", 64'(uop_addr), 64'd127);
        check("s4_last_instr", 64'(slot_instr[0]), 64'd382);
        check("s4_last_tag1", 64'(slot_tag[1]), 64'd0);
        step(3);
        check("s4_no_wrap", 64'(uop_addr), 64'd127);
        check("s4_quiet", 64'(slot_valid[1]), 64'd0);
`ifdef MICROCODE_PERF_EN
        check("s4_cnt", 64'(issue_cnt), 64'd256);
`endif

        // Scenario 5: empty store halts on the first edge
        hold_reset();
        clear_mem();
        release_reset();
        step(1);
        check("s5_halted", 64'(halted), 64'd1);
        check("s5_addr", 64'(uop_addr), 64'd0);
        check("s5_valid", 64'(slot_valid[0]), 64'd0);
        step(3);
        check("s5_hold", 64'(halted), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
